load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits directly upstream of the 32-word data memory.
- Converts RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-granular memory accesses.
- Sub-word stores use read-modify-write.
- Loads get byte/halfword extraction with sign or zero extension.
- Multi-cycle, with a req/busy/done handshake to the core.

Parameters:
- ADDR_W, 5, word-index width driven to memory (memory depth = 2**ADDR_W words).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  1  request strobe; sampled only in IDLE.
- is_store  input  1  1 = store, 0 = load.
- funct3  input  3  RV32I width/sign code.
- base  input  32  rs1 value.
- offset  input  32  sign-extended immediate.
- store_data  input  32  rs2 value.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle completion pulse.
- fault  output  1  valid with done; misaligned or illegal funct3.
- load_data  output  32  extended load result; holds until the next load completes.
- mem_addr  output  32  to memory rs1; word index zero-extended.
- mem_imm  output  32  to memory Immediate; constant 0.
- mem_wdata  output  32  to memory dataIN.
- mem_rw  output  1  to memory readWrite; 1 = read, 0 = write.
- mem_rdata  input  32  from memory dataOUT; registered, valid one edge after mem_rw=1 with a stable address.

Behaviour:
- Reset values: state=IDLE, busy=0, done=0, fault=0, load_data=0, mem_addr=0, mem_wdata=0, mem_rw=1.
- mem_rw rule: the memory writes on every edge where readWrite=0, so mem_rw=0 only in WRITE. It is 1 in all other states and during reset.
- Accept: in IDLE, if req=1, latch ea=base+offset (32-bit, carry discarded), lane=ea[1:0], widx=ea[ADDR_W+1:2], funct3, is_store, store_data.
- Legal funct3:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - Anything else is illegal.
- Misaligned: halfword with lane[0]=1; word with lane!=0.
- Illegal or misaligned: IDLE->DONE with fault=1. No memory cycle, and load_data is unchanged.
- States: IDLE, READ, EXT, MERGE, WRITE, DONE.
- Loads: IDLE->READ->EXT->DONE.
  - READ drives mem_addr=widx, mem_rw=1.
  - EXT registers load_data from mem_rdata.
  - Byte select uses lane*8.
  - Halfword select uses lane[1]*16.
  - 000/001 sign-extend; 100/101 zero-extend.
- SW: IDLE->WRITE->DONE. WRITE drives mem_wdata=store_data, mem_rw=0.
- SB/SH: IDLE->READ->MERGE->WRITE->DONE. MERGE replaces only the addressed byte or halfword of mem_rdata with store_data[7:0] or [15:0] and registers the result into mem_wdata.
- Latency from accept edge to done-high cycle:
  - Load: 3 cycles.
  - SW: 2 cycles.
  - SB/SH: 4 cycles.
  - Fault: 1 cycle.
- DONE: done=1 for exactly one cycle, then IDLE. req during any non-IDLE state, including DONE, is ignored and not queued.
- Address wrap: ea wraps modulo 2**32; the word index uses only ea[ADDR_W+1:2].
- Reset mid-operation: immediate return to reset values.
  - A WRITE in flight at reset assertion may or may not complete.
  - A partial RMW never writes a stale merge after reset.

Optional Feature:
- Macro: LSU_ADDR_CHECK_EN.
- Defined: ea[31:ADDR_W+2] != 0 is a fault (IDLE->DONE, fault=1, no memory access).
- Undefined: upper bits are ignored and the address aliases modulo memory size.

Test Plan:
- SW base=0x10, offset=0x4, data=0xDEADBEEF, then LW same address -> word 5 = 0xDEADBEEF; done 2 cycles after store accept; load_data=0xDEADBEEF 3 cycles after load accept.
- Word 5 = 0xDEADBEEF, SB ea=0x16, data=0x55 -> word 5 = 0xDE55BEEF; mem_rw=0 for exactly one cycle; done 4 cycles after accept.
- LB ea=0x17 -> 0xFFFFFFDE; LBU ea=0x17 -> 0x000000DE; LH ea=0x14 -> 0xFFFFBEEF; LHU ea=0x16 -> 0x0000DE55.
- LW ea=0x2 and SH ea=0x1 -> fault=1 with done 1 cycle after accept; mem_rw stays 1; memory and load_data unchanged.
- Assert rst during MERGE of an SB -> all outputs at reset values immediately; target word unchanged; a new LW after release completes normally.
- ea=0x100 with LSU_ADDR_CHECK_EN -> fault=1; without it -> accesses word 0.

Source files
------------

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Converts RV32I loads/stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into
//               word-granular accesses on a registered-read data memory.
//               Sub-word stores use read-modify-write; loads are byte/half
//               extracted and sign/zero extended. req/busy/done handshake.
// Optional    : define LSU_ADDR_CHECK_EN to fault on effective addresses
//               whose bits above the memory index are non-zero.
// Ports       : clk, rst (async, active high)
//               req, is_store, funct3, base, offset, store_data  (core in)
//               busy, done, fault, load_data                     (core out)
//               mem_addr, mem_imm, mem_wdata, mem_rw              (memory out)
//               mem_rdata                                         (memory in)
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int ADDR_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] base,
    input  logic [31:0] offset,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [31:0] load_data,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_imm,
    output logic [31:0] mem_wdata,
    output logic        mem_rw,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_EXT   = 3'd2,
        S_MERGE = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [1:0]          r_lane;
    logic [ADDR_W-1:0]   r_widx;
    logic [2:0]          r_funct3;
    logic                r_is_store;
    logic [15:0]         r_sdata;
    logic                r_fault;
    logic [31:0]         r_load_data;
    logic [31:0]         r_wdata;

    logic [31:0]         w_ea;
    logic [1:0]          w_lane;
    logic                w_legal;
    logic                w_misal;
    logic                w_upper_bad;
    logic                w_fault;
    logic [31:0]         w_shifted;
    logic [15:0]         w_half;
    logic [31:0]         w_ext;
    logic [31:0]         w_merge;

    assign w_ea   = base + offset;    // carry out intentionally discarded
    assign w_lane = w_ea[1:0];

    always_comb begin
        w_legal = 1'b0;
        if (is_store) begin
            w_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        end else begin
            w_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                      (funct3 == 3'b100) || (funct3 == 3'b101);
        end
    end

    // funct3[1:0] encodes the access size for every legal code.
    always_comb begin
        w_misal = 1'b0;
        case (funct3[1:0])
            2'b01:   w_misal = w_lane[0];
            2'b10:   w_misal = (w_lane != 2'b00);
            default: w_misal = 1'b0;
        endcase
    end

`ifdef LSU_ADDR_CHECK_EN
    assign w_upper_bad = |w_ea[31:ADDR_W+2];
`else
    // Upper address bits alias onto the memory; they are deliberately dropped.
    logic w_unused_upper;
    assign w_unused_upper = &{1'b0, w_ea[31:ADDR_W+2]};
    assign w_upper_bad    = 1'b0;
`endif

    assign w_fault = !w_legal || w_misal || w_upper_bad;

    // ------------------------------------------------------------------
    // State register and next-state logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    if (w_fault) begin
                        w_next = S_DONE;
                    end else if (is_store && (funct3[1:0] == 2'b10)) begin
                        w_next = S_WRITE;
                    end else begin
                        w_next = S_READ;
                    end
                end
            end
            S_READ:  w_next = r_is_store ? S_MERGE : S_EXT;
            S_EXT:   w_next = S_DONE;
            S_MERGE: w_next = S_WRITE;
            S_WRITE: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Load extraction and store merge, both on the word read back in READ
    // ------------------------------------------------------------------
    assign w_shifted = mem_rdata >> {r_lane, 3'b000};
    assign w_half    = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        w_ext = mem_rdata;
        case (r_funct3)
            3'b000:  w_ext = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_ext = {24'd0, w_shifted[7:0]};
            3'b101:  w_ext = {16'd0, w_half};
            default: w_ext = mem_rdata;
        endcase
    end

    always_comb begin
        w_merge = mem_rdata;
        if (r_funct3[1:0] == 2'b00) begin
            w_merge[{r_lane, 3'b000} +: 8] = r_sdata[7:0];
        end else begin
            w_merge[{r_lane[1], 4'b0000} +: 16] = r_sdata;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers. r_wdata is cleared by reset so an interrupted
    // read-modify-write can never later write a stale merged word.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lane      <= 2'd0;
            r_widx      <= '0;
            r_funct3    <= 3'd0;
            r_is_store  <= 1'b0;
            r_sdata     <= 16'd0;
            r_fault     <= 1'b0;
            r_load_data <= 32'd0;
            r_wdata     <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_lane     <= w_lane;
                        r_widx     <= w_ea[ADDR_W+1:2];
                        r_funct3   <= funct3;
                        r_is_store <= is_store;
                        r_sdata    <= store_data[15:0];
                        r_fault    <= w_fault;
                        r_wdata    <= store_data;
                    end
                end
                S_EXT:   r_load_data <= w_ext;
                S_MERGE: r_wdata     <= w_merge;
                default: ;
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign fault     = r_fault && (r_state == S_DONE);
    assign load_data = r_load_data;
    assign mem_addr  = {{(32-ADDR_W){1'b0}}, r_widx};
    assign mem_imm   = 32'd0;
    assign mem_wdata = r_wdata;
    assign mem_rw    = (r_state != S_WRITE);

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Scoreboard bench for load_store_unit with a 32-word
//               registered-read memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] base;
    logic [31:0] offset;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic        fault;
    logic [31:0] load_data;
    logic [31:0] mem_addr;
    logic [31:0] mem_imm;
    logic [31:0] mem_wdata;
    logic        mem_rw;
    logic [31:0] mem_rdata;

    load_store_unit #(.ADDR_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .is_store   (is_store),
        .funct3     (funct3),
        .base       (base),
        .offset     (offset),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .fault      (fault),
        .load_data  (load_data),
        .mem_addr   (mem_addr),
        .mem_imm    (mem_imm),
        .mem_wdata  (mem_wdata),
        .mem_rw     (mem_rw),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: writes on every edge with readWrite=0, registered read.
    logic [31:0] mem [0:31];
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
        mem_rdata = 32'd0;
    end
    always @(posedge clk) begin
        if (!mem_rw) mem[mem_addr[4:0]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[4:0]];
    end

    int cyc  = 0;
    int wcnt = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (!mem_rw) wcnt <= wcnt + 1;

    int checks   = 0;
    int failures = 0;

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic        fault;
        logic [31:0] ld;
        int          cyc;
    } exp_t;
    exp_t q[$];

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 expected no pending op");
            end else begin
                exp_t e;
                e = q.pop_front();
                chk({e.name, "_fault"}, {31'd0, fault}, {31'd0, e.fault});
                chk({e.name, "_load_data"}, load_data, e.ld);
                chk({e.name, "_done_cycle"}, cyc, e.cyc);
            end
        end
    end

    logic [31:0] last_ld = 32'd0;

    // Issues one request from a negedge with the DUT idle; returns at a
    // negedge once it is idle again.
    task automatic do_op(string nm, logic st, logic [2:0] f3, logic [31:0] b,
                         logic [31:0] o, logic [31:0] d, logic ef,
                         logic [31:0] eld, int lat, int ew);
        exp_t e;
        int   w0;
        int   n;
        req = 1'b1; is_store = st; funct3 = f3; base = b; offset = o; store_data = d;
        e.name = nm; e.fault = ef; e.ld = eld; e.cyc = cyc + lat;
        q.push_back(e);
        w0 = wcnt;
        @(posedge clk);
        #1 req = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 20);
        chk({nm, "_timeout"}, {31'd0, busy}, 32'd0);
        chk({nm, "_drained"}, q.size(), 32'd0);
        chk({nm, "_write_cycles"}, wcnt - w0, ew);
        q.delete();
        last_ld = eld;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = 1'b0; is_store = 1'b0; funct3 = 3'd0;
        base = 32'd0; offset = 32'd0; store_data = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_rw", {31'd0, mem_rw}, 32'd1);
        chk("mem_imm", mem_imm, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Word store / load
        do_op("sw5", 1'b1, 3'b010, 32'h10, 32'h4, 32'hDEADBEEF, 1'b0, last_ld, 2, 1);
        chk("mem5_after_sw", mem[5], 32'hDEADBEEF);
        do_op("lw5", 1'b0, 3'b010, 32'h10, 32'h4, 32'h0, 1'b0, 32'hDEADBEEF, 3, 0);

        // Byte read-modify-write
        do_op("sb16", 1'b1, 3'b000, 32'h10, 32'h6, 32'h00000055, 1'b0, last_ld, 4, 1);
        chk("mem5_after_sb", mem[5], 32'hDE55BEEF);

        // Extraction and extension
        do_op("lb17",  1'b0, 3'b000, 32'h17, 32'h0, 32'h0, 1'b0, 32'hFFFFFFDE, 3, 0);
        do_op("lbu17", 1'b0, 3'b100, 32'h17, 32'h0, 32'h0, 1'b0, 32'h000000DE, 3, 0);
        do_op("lh14",  1'b0, 3'b001, 32'h14, 32'h0, 32'h0, 1'b0, 32'hFFFFBEEF, 3, 0);
        do_op("lhu16", 1'b0, 3'b101, 32'h16, 32'h0, 32'h0, 1'b0, 32'h0000DE55, 3, 0);
        do_op("lbu15", 1'b0, 3'b100, 32'h15, 32'h0, 32'h0, 1'b0, 32'h000000BE, 3, 0);

        // Halfword RMW with a carry-discarding effective address (0x12)
        do_op("sh12", 1'b1, 3'b001, 32'h20, 32'hFFFFFFF2, 32'h1234ABCD, 1'b0, last_ld, 4, 1);
        chk("mem4_after_sh", mem[4], 32'hABCD0000);
        do_op("lh12", 1'b0, 3'b001, 32'h12, 32'h0, 32'h0, 1'b0, 32'hFFFFABCD, 3, 0);

        // Faults: misaligned and illegal funct3
        do_op("lw_mis",  1'b0, 3'b010, 32'h2, 32'h0, 32'h0, 1'b1, last_ld, 1, 0);
        do_op("sh_mis",  1'b1, 3'b001, 32'h1, 32'h0, 32'hFFFF, 1'b1, last_ld, 1, 0);
        do_op("ld_f011", 1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1, last_ld, 1, 0);
        do_op("st_f100", 1'b1, 3'b100, 32'h14, 32'h0, 32'h0, 1'b1, last_ld, 1, 0);
        chk("mem5_after_faults", mem[5], 32'hDE55BEEF);
        chk("mem0_after_faults", mem[0], 32'h0);

        // Reset asserted while an SB is in MERGE
        begin
            int w0;
            w0 = wcnt;
            req = 1'b1; is_store = 1'b1; funct3 = 3'b000;
            base = 32'h14; offset = 32'h0; store_data = 32'h77;
            @(posedge clk);           // accept -> READ
            #1 req = 1'b0;
            @(posedge clk);           // READ -> MERGE
            #2 rst = 1'b1;
            #1;
            chk("mrst_busy", {31'd0, busy}, 32'd0);
            chk("mrst_done", {31'd0, done}, 32'd0);
            chk("mrst_load_data", load_data, 32'd0);
            chk("mrst_mem_rw", {31'd0, mem_rw}, 32'd1);
            chk("mrst_mem_wdata", mem_wdata, 32'd0);
            chk("mrst_mem_addr", mem_addr, 32'd0);
            @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
            last_ld = 32'd0;
            @(negedge clk);
            chk("mrst_write_cycles", wcnt - w0, 32'd0);
            chk("mem5_after_mrst", mem[5], 32'hDE55BEEF);
        end
        do_op("lw5_post_rst", 1'b0, 3'b010, 32'h14, 32'h0, 32'h0, 1'b0, 32'hDE55BEEF, 3, 0);

        // Upper address bits
`ifdef LSU_ADDR_CHECK_EN
        do_op("sw_100", 1'b1, 3'b010, 32'h100, 32'h0, 32'hCAFEF00D, 1'b1, last_ld, 1, 0);
        chk("mem0_after_sw100", mem[0], 32'h0);
        do_op("lw_0", 1'b0, 3'b010, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 3, 0);
`else
        do_op("sw_100", 1'b1, 3'b010, 32'h100, 32'h0, 32'hCAFEF00D, 1'b0, last_ld, 2, 1);
        chk("mem0_after_sw100", mem[0], 32'hCAFEF00D);
        do_op("lw_0", 1'b0, 3'b010, 32'h0, 32'h0, 32'h0, 1'b0, 32'hCAFEF00D, 3, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
